// File: rtl/vx_fetch_sched_if.sv
// Fetch request handshake between the warp scheduler (master) and the fetch stage (slave).
// The fetch stage accepts a request in any cycle where sched_valid and sched_ready are both 1.
interface vx_fetch_sched_if #(
  parameter int NUM_WARPS = 4
);
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic                sched_valid;
  logic [NW_WIDTH-1:0] sched_wid;
  logic                sched_ready;

  modport master (output sched_valid, output sched_wid, input sched_ready);
  modport slave  (input sched_valid, input sched_wid, output sched_ready);
endinterface

// File: rtl/vx_fetch_sched.sv
// Credit-based round-robin fetch scheduler: one instruction-buffer credit per slot per warp,
// with a registered request that is held stable until the fetch stage accepts it.
module vx_fetch_sched #(
  parameter int NUM_WARPS = 4,
  parameter int IBUF_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WARPS-1:0] warp_active,
  input  logic [NUM_WARPS-1:0] warp_stall,
  input  logic [NUM_WARPS-1:0] ibuf_pop,
  vx_fetch_sched_if.master     fetch,
  output logic [NUM_WARPS-1:0] warp_idle,
  output logic                 busy
);
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int CW       = $clog2(IBUF_SIZE + 1);
  localparam logic [CW-1:0]       FULL     = CW'(IBUF_SIZE);
  localparam logic [NW_WIDTH-1:0] LAST_WID = NW_WIDTH'(NUM_WARPS - 1);

  logic [NUM_WARPS-1:0][CW-1:0] credit;
  logic [NUM_WARPS-1:0][CW-1:0] credit_n;
  logic [NUM_WARPS-1:0]         fire_sel;
  logic [NUM_WARPS-1:0]         elig_n;
  logic [NUM_WARPS-1:0]         pop_ovf;
  logic                         valid_q;
  logic [NW_WIDTH-1:0]          wid_q;
  logic [NW_WIDTH-1:0]          rr_ptr;
  logic                         started;
  logic                         fire;
  logic                         load;
  logic                         sel_found;
  logic [NW_WIDTH-1:0]          sel_wid;

  assign fire = valid_q && fetch.sched_ready;
  // started delays the first load by one edge after reset release
  assign load = started && (!valid_q || fire);

  always_comb begin
    fire_sel = '0;
    pop_ovf  = '0;
    elig_n   = '0;
    credit_n = credit;
    for (int i = 0; i < NUM_WARPS; i++) begin
      fire_sel[i] = fire && (wid_q == NW_WIDTH'(i));
      pop_ovf[i]  = ibuf_pop[i] && !fire_sel[i] && (credit[i] == FULL);
      if (fire_sel[i] && !ibuf_pop[i]) begin
        credit_n[i] = credit[i] - CW'(1);
      end else if (ibuf_pop[i] && !fire_sel[i] && (credit[i] != FULL)) begin
        credit_n[i] = credit[i] + CW'(1);
      end
      elig_n[i] = warp_active[i] && !warp_stall[i] && (credit_n[i] != '0);
    end
  end

  // Round-robin search starting one past the last granted warp
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_wid   = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_WARPS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
      if (!sel_found && elig_n[idx]) begin
        sel_found = 1'b1;
        sel_wid   = NW_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit  <= {NUM_WARPS{FULL}};
      valid_q <= 1'b0;
      wid_q   <= '0;
      rr_ptr  <= LAST_WID;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      credit  <= credit_n;
      if (load) begin
        valid_q <= sel_found;
        if (sel_found) begin
          wid_q  <= sel_wid;
          rr_ptr <= sel_wid;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      warp_idle[i] = (credit[i] == FULL);
    end
  end

  assign busy              = valid_q || !(&warp_idle);
  assign fetch.sched_valid = valid_q;
  assign fetch.sched_wid   = wid_q;

  // A credit return on a warp that already holds every credit means the buffer lost track
  a_pop_overflow : assert property (@(posedge clk) disable iff (!reset) pop_ovf == '0);
endmodule
